// File: rtl/iir_biquad_sequencer.sv
// Direct-form-I biquad that shares one external 16x16 multiplier across its five taps.
// It accumulates the taps in Q.28, then rounds and saturates the result back to Q1.15.
module iir_biquad_sequencer #(
    parameter int ACC_W     = 36,
    parameter int OUT_SHIFT = 13,
    parameter int ROUND_EN  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_sat,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    output logic        cfg_err,
    output logic        mul_en,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic [31:0] mul_p,
    input  logic        mul_valid,
    output logic        mul_ready,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ROUND, OUT} state_t;

    localparam logic signed [ACC_W-1:0] RND =
        (ROUND_EN != 0) ? ({{(ACC_W-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1)) : '0;
    localparam logic signed [ACC_W-1:0] MAX_Y = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MIN_Y = ACC_W'(-32768);

    state_t state, state_next;

    logic [15:0] b0, b1, b2, a1, a2;
    logic [15:0] x, x1, x2, y1, y2;
    logic signed [ACC_W-1:0] acc;
    logic [2:0] idx;

    logic [15:0] sel_coef, sel_data;
    logic signed [ACC_W-1:0] prod_ext, rounded, shifted;
    logic [15:0] y_clamped;
    logic y_sat;

    always_comb begin
        sel_coef = b0;
        sel_data = x;
        case (idx)
            3'd1:    begin sel_coef = b1; sel_data = x1; end
            3'd2:    begin sel_coef = b2; sel_data = x2; end
            3'd3:    begin sel_coef = a1; sel_data = y1; end
            3'd4:    begin sel_coef = a2; sel_data = y2; end
            default: begin sel_coef = b0; sel_data = x;  end
        endcase
    end

    // Round half up (optional), arithmetic shift back to Q.15, then clamp to 16 bits.
    always_comb begin
        prod_ext  = {{(ACC_W-32){mul_p[31]}}, mul_p};
        rounded   = acc + RND;
        shifted   = rounded >>> OUT_SHIFT;
        y_sat     = 1'b0;
        y_clamped = shifted[15:0];
        if (shifted > MAX_Y) begin
            y_clamped = 16'h7FFF;
            y_sat     = 1'b1;
        end else if (shifted < MIN_Y) begin
            y_clamped = 16'h8000;
            y_sat     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        mul_en     = 1'b0;
        mul_ready  = 1'b0;
        out_valid  = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (!clr && in_valid) state_next = ISSUE;
            end
            ISSUE: begin
                mul_en     = 1'b1;
                mul_a      = sel_coef;
                mul_b      = sel_data;
                state_next = WAIT;
            end
            WAIT: begin
                mul_ready = 1'b1;
                mul_a     = sel_coef;
                mul_b     = sel_data;
                if (mul_valid) state_next = (idx == 3'd4) ? ROUND : ISSUE;
            end
            ROUND: state_next = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Coefficient writes only land while idle; anything else is flagged and dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b0 <= '0; b1 <= '0; b2 <= '0; a1 <= '0; a2 <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (cfg_we) begin
                if (state != IDLE) begin
                    cfg_err <= 1'b1;
                end else begin
                    case (cfg_addr)
                        3'd0:    b0 <= cfg_data;
                        3'd1:    b1 <= cfg_data;
                        3'd2:    b2 <= cfg_data;
                        3'd3:    a1 <= cfg_data;
                        3'd4:    a2 <= cfg_data;
                        default: cfg_err <= 1'b1;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0; x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
            acc      <= '0;
            idx      <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
                    end else if (in_valid) begin
                        x   <= in_data;
                        acc <= '0;
                        idx <= '0;
                    end
                end
                WAIT: begin
                    if (mul_valid) begin
                        acc <= (idx < 3'd3) ? acc + prod_ext : acc - prod_ext;
                        if (idx != 3'd4) idx <= idx + 3'd1;
                    end
                end
                ROUND: begin
                    out_data <= y_clamped;
                    out_sat  <= y_sat;
                    x2 <= x1;
                    x1 <= x;
                    y2 <= y1;
                    y1 <= y_clamped;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_sequencer.sv
// Directed bench for iir_biquad_sequencer with a behavioural multiplier of configurable delay.
module tb_iir_biquad_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_sat;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic        cfg_err;
    logic        mul_en;
    logic [15:0] mul_a, mul_b;
    logic [31:0] mul_p;
    logic        mul_valid;
    logic        mul_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int mul_delay = 1;

    logic        mv;
    logic        pend;
    int          cnt;
    logic [31:0] prod;

    always #5 clk = ~clk;

    iir_biquad_sequencer dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .busy(busy)
    );

    // Multiplier model: product valid mul_delay cycles after the mul_en edge, held until accepted.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv <= 1'b0; pend <= 1'b0; cnt <= 0; prod <= '0;
        end else begin
            if (mv && mul_ready) mv <= 1'b0;
            if (mul_en) begin
                prod <= 32'($signed(mul_a) * $signed(mul_b));
                if (mul_delay <= 1) mv <= 1'b1;
                else begin pend <= 1'b1; cnt <= mul_delay - 1; end
            end else if (pend) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin mv <= 1'b1; pend <= 1'b0; end
            end
        end
    end
    assign mul_valid = mv;
    assign mul_p     = prod;

    task automatic write_cfg(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    // Latency counts the accept edge as cycle 1; out_valid is sampled 1 ns after each edge.
    task automatic run_sample(input logic [15:0] xin, output logic [15:0] y, output logic sat,
                              output int lat);
        int guard;
        @(negedge clk);
        in_data = xin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        guard = 0;
        while (!out_valid && guard < 300) begin
            @(posedge clk); #1;
            lat++; guard++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("[TB] FAIL sample_timeout: out_valid=%0b required 1", out_valid);
        end
        y = out_data; sat = out_sat;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if ({in_ready, busy, out_valid, out_sat, cfg_err, mul_en, mul_ready} !== 7'b1000000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b required 1000000",
                     {in_ready, busy, out_valid, out_sat, cfg_err, mul_en, mul_ready});
        end
        checks++;
        if ({out_data, mul_a, mul_b} !== 48'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h required 0", {out_data, mul_a, mul_b});
        end
    endtask

    task automatic test_passthrough();
        logic [15:0] y; logic sat; int lat;
        write_cfg(3'd0, 16'h2000);
        run_sample(16'h4000, y, sat, lat);
        checks++;
        if (y !== 16'h4000) begin errors++; $display("[TB] FAIL pass_y: got %h required 4000", y); end
        checks++;
        if (sat !== 1'b0) begin errors++; $display("[TB] FAIL pass_sat: got %b required 0", sat); end
        checks++;
        if (lat != 12) begin errors++; $display("[TB] FAIL pass_latency: got %0d required 12", lat); end
    endtask

    task automatic test_history();
        logic [15:0] y; logic sat; int lat;
        logic [15:0] exp_y [3] = '{16'h2000, 16'h4000, 16'h6000};
        write_cfg(3'd1, 16'h2000);
        write_cfg(3'd2, 16'h2000);
        do_clr();
        for (int i = 0; i < 3; i++) begin
            run_sample(16'h2000, y, sat, lat);
            checks++;
            if (y !== exp_y[i]) begin
                errors++;
                $display("[TB] FAIL history_y%0d: got %h required %h", i, y, exp_y[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] y; logic sat; int lat;
        write_cfg(3'd1, 16'h0000);
        write_cfg(3'd2, 16'h0000);
        write_cfg(3'd0, 16'h7FFF);
        do_clr();
        run_sample(16'h7FFF, y, sat, lat);
        checks++;
        if ({y, sat} !== {16'h7FFF, 1'b1}) begin
            errors++; $display("[TB] FAIL sat_pos: got y=%h sat=%b required 7fff/1", y, sat);
        end
        run_sample(16'h8000, y, sat, lat);
        checks++;
        if ({y, sat} !== {16'h8000, 1'b1}) begin
            errors++; $display("[TB] FAIL sat_neg: got y=%h sat=%b required 8000/1", y, sat);
        end
    endtask

    task automatic test_feedback();
        logic [15:0] y; logic sat; int lat;
        write_cfg(3'd0, 16'h1000);
        write_cfg(3'd3, 16'hE000);
        do_clr();
        run_sample(16'h2000, y, sat, lat);
        checks++;
        if (y !== 16'h1000) begin errors++; $display("[TB] FAIL fb_first: got %h required 1000", y); end
        run_sample(16'h0000, y, sat, lat);
        checks++;
        if (y !== 16'h1000) begin errors++; $display("[TB] FAIL fb_second: got %h required 1000", y); end
    endtask

    task automatic test_backpressure();
        int guard;
        write_cfg(3'd0, 16'h2000);
        write_cfg(3'd3, 16'h0000);
        do_clr();
        mul_delay = 3;
        @(negedge clk);
        in_data = 16'h4000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 300) begin @(posedge clk); #1; guard++; end
        checks++;
        if (out_data !== 16'h4000) begin
            errors++; $display("[TB] FAIL bp_y: got %h required 4000", out_data);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, 16'h4000}) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got valid=%b ready=%b y=%h required 1/0/4000",
                         i, out_valid, in_ready, out_data);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("[TB] FAIL bp_release: got %b required 01", {out_valid, in_ready});
        end
        mul_delay = 1;
    endtask

    task automatic test_cfg_reject();
        logic [15:0] y; logic sat; int lat;
        write_cfg(3'd5, 16'h1234);
        checks++;
        if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL cfg_bad_addr: got %b required 1", cfg_err); end
        @(posedge clk); #1;
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL cfg_pulse: got %b required 0", cfg_err); end
        mul_delay = 3;
        fork
            run_sample(16'h4000, y, sat, lat);
            begin
                repeat (4) @(posedge clk);
                write_cfg(3'd0, 16'h0000);
                checks++;
                if (cfg_err !== 1'b1) begin
                    errors++; $display("[TB] FAIL cfg_busy_err: got %b required 1", cfg_err);
                end
            end
        join
        mul_delay = 1;
        checks++;
        if (y !== 16'h4000) begin errors++; $display("[TB] FAIL cfg_busy_y: got %h required 4000", y); end
        run_sample(16'h4000, y, sat, lat);
        checks++;
        if (y !== 16'h4000) begin errors++; $display("[TB] FAIL cfg_kept: got %h required 4000", y); end
    endtask

    task automatic test_reset_in_wait();
        logic [15:0] y; logic sat; int lat;
        int guard;
        mul_delay = 30;
        @(negedge clk);
        in_data = 16'h4000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (!mul_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy, out_valid, cfg_err, mul_en, mul_ready, mul_a, mul_b, out_data}
            !== {6'b100000, 48'h0}) begin
            errors++;
            $display("[TB] FAIL wait_reset: ready=%b busy=%b mul_ready=%b a=%h b=%h y=%h",
                     in_ready, busy, mul_ready, mul_a, mul_b, out_data);
        end
        mul_delay = 1;
        @(negedge clk);
        rst_n = 1'b1;
        run_sample(16'h4000, y, sat, lat);
        checks++;
        if (y !== 16'h0000) begin errors++; $display("[TB] FAIL coef_cleared: got %h required 0000", y); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_passthrough();
        test_history();
        test_saturation();
        test_feedback();
        test_backpressure();
        test_cfg_reject();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
